// File: rtl/phase_sequencer_pkg.sv
// Shared types and lamp encodings for the four-phase intersection sequencer.
// Lane order everywhere is phase order: SS-straight, SS-turn, CS-straight, CS-turn.
package phase_sequencer_pkg;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        PH_SS_STRAIGHT = 2'd0,
        PH_SS_TURN     = 2'd1,
        PH_CS_STRAIGHT = 2'd2,
        PH_CS_TURN     = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_t;

    function automatic logic is_turn(input phase_t p);
        return (p == PH_SS_TURN) || (p == PH_CS_TURN);
    endfunction

    // Full 8-bit lamp word: only the active phase's lane is lit.
    function automatic logic [7:0] lamp_word(input state_t st, input phase_t p);
        logic [1:0] color;
        case (st)
            ST_GREEN:  color = LAMP_GREEN;
            ST_YELLOW: color = LAMP_YELLOW;
            default:   color = LAMP_RED;
        endcase
        return {6'b000000, color} << {p, 1'b0};
    endfunction

endpackage

// File: rtl/phase_sequencer_prescaler.sv
// Seconds prescaler: wraps 0..CLK_HZ-1 and flags the last cycle of each second.
module sec_prescaler #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic sec_tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign sec_tick = (count == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase traffic sequencer: green/yellow/all-red per phase, demand-skipped turns,
// gap-out on idle approach, and pedestrian walk on straight phases.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CLK_HZ           = 1000,
    parameter int GREEN_STRAIGHT_S = 120,
    parameter int GREEN_TURN_S     = 60,
    parameter int MIN_GREEN_S      = 10,
    parameter int YELLOW_S         = 4,
    parameter int ALL_RED_S        = 2,
    parameter int WALK_S           = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sensor,
    input  logic [1:0] ped_req,
    output logic [7:0] lamp,
    output logic [1:0] walk,
    output logic [1:0] phase,
    output logic       sec_tick
);

    localparam int MAX_GREEN_S = (GREEN_STRAIGHT_S > GREEN_TURN_S) ? GREEN_STRAIGHT_S : GREEN_TURN_S;
    localparam int MAX_CLEAR_S = (YELLOW_S > ALL_RED_S) ? YELLOW_S : ALL_RED_S;
    localparam int MAX_STATE_S = (MAX_GREEN_S > MAX_CLEAR_S) ? MAX_GREEN_S : MAX_CLEAR_S;
    localparam int IW          = $clog2(MAX_STATE_S + 1);

    localparam logic [IW-1:0] STRAIGHT_LAST = IW'(GREEN_STRAIGHT_S - 1);
    localparam logic [IW-1:0] TURN_LAST     = IW'(GREEN_TURN_S - 1);
    localparam logic [IW-1:0] MIN_LAST      = IW'(MIN_GREEN_S - 1);
    localparam logic [IW-1:0] YELLOW_LAST   = IW'(YELLOW_S - 1);
    localparam logic [IW-1:0] ALL_RED_LAST  = IW'(ALL_RED_S - 1);
    localparam logic [IW-1:0] WALK_LAST     = IW'(WALK_S - 1);

    state_t        state, state_next;
    phase_t        cur_phase, phase_next, next_green;
    logic [IW-1:0] interval, interval_next, green_last;
    logic [3:0]    demand, demand_next, lane_mask;
    logic [1:0]    ped_latch, ped_next, walk_next;
    logic          gap_out;

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (sec_tick)
    );

    // Successor phase when leaving all-red; a turn with no waiting car is passed over.
    always_comb begin
        next_green = phase_t'(cur_phase + 2'd1);
        if (is_turn(next_green) && !demand[next_green]) begin
            next_green = phase_t'(cur_phase + 2'd2);
        end
    end

    assign lane_mask  = 4'b0001 << cur_phase;
    assign green_last = is_turn(cur_phase) ? TURN_LAST : STRAIGHT_LAST;
    assign gap_out    = (interval >= MIN_LAST) && !sensor[cur_phase] && (walk == 2'b00)
                        && ((demand & ~lane_mask) != 4'b0000);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        phase_next    = cur_phase;
        interval_next = sec_tick ? interval + IW'(1) : interval;
        walk_next     = walk;
        demand_next   = demand | sensor;
        ped_next      = ped_latch | ped_req;

        case (state)
            ST_GREEN: begin
                if (sec_tick && interval == WALK_LAST) begin
                    walk_next = 2'b00;
                end
                if (sec_tick && (interval == green_last || gap_out)) begin
                    state_next    = ST_YELLOW;
                    interval_next = '0;
                    walk_next     = 2'b00;
                end
            end
            ST_YELLOW: begin
                if (sec_tick && interval == YELLOW_LAST) begin
                    state_next    = ST_ALL_RED;
                    interval_next = '0;
                end
            end
            ST_ALL_RED: begin
                if (sec_tick && interval == ALL_RED_LAST) begin
                    state_next    = ST_GREEN;
                    phase_next    = next_green;
                    interval_next = '0;
                    // A car arriving on the very entry cycle keeps its latch set.
                    demand_next[next_green] = sensor[next_green];
                    if (!is_turn(next_green) && ped_latch[next_green == PH_CS_STRAIGHT]) begin
                        walk_next[next_green == PH_CS_STRAIGHT] = 1'b1;
                        ped_next[next_green == PH_CS_STRAIGHT]  = ped_req[next_green == PH_CS_STRAIGHT];
                    end
                end
            end
            default: begin
                state_next    = ST_ALL_RED;
                interval_next = '0;
                walk_next     = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_GREEN;
            cur_phase <= PH_SS_STRAIGHT;
            interval  <= '0;
            demand    <= 4'b0000;
            ped_latch <= 2'b00;
            walk      <= 2'b00;
            lamp      <= 8'h00;
        end else begin
            state     <= state_next;
            cur_phase <= phase_next;
            interval  <= interval_next;
            demand    <= demand_next;
            ped_latch <= ped_next;
            walk      <= walk_next;
            lamp      <= lamp_word(state_next, phase_next);
        end
    end

    assign phase = cur_phase;

endmodule
